multicycle_controller: RTL
==========================

# multicycle_controller

Parametrised, state-machine successor to the single-cycle main decoder. It sequences one RV32I instruction at a time through fetch, decode, execute, memory and writeback states on a shared-memory multicycle datapath. Memory accesses use a ready handshake with optional wait states. An optional multi-cycle M-extension unit is supported. The block sits between the instruction register and ALU flags on one side and the datapath mux selects and write strobes on the other; the ALU decoder remains a separate block driven by ALUOp.

## Interface
Parameters:
- MEM_HANDSHAKE, 1, 1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready ignored, treated as 1
- M_EXT, 0, 1: op=0110011 with funct7_b0=1 is routed to the MUL states; 0: it is treated as a plain R-type

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instruction opcode (IR[6:0])
- funct3  in  3  IR[14:12]
- funct7_b0  in  1  IR[25]
- Zero, ALUR31  in  1  ALU zero flag and ALU result bit 31
- mem_ready  in  1  memory completes the access this cycle
- mul_done  in  1  multiply/divide result valid this cycle
- PCWrite, IRWrite, RegWrite, MemWrite  out  1  write strobes
- AdrSrc  out  1  0=PC, 1=ALUOut
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
- ALUOp  out  2  00=add, 01=branch compare, 10=funct-decoded
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op
- mem_req, mul_start  out  1  access request; one-cycle multiply launch
- illegal  out  1  high while in TRAP
- instr_retired  out  1  one-cycle pulse on the last cycle of each instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUIWB, MULSTART, MULWAIT, TRAP.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Go to DECODE when mem_ready, else hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which computes the branch/jal target into ALUOut. Dispatch on op:
  - 0000011 and 0100011 → MEMADR
  - 0110011 → EXECR, or MULSTART if M_EXT and funct7_b0
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUIWB
  - 0010111 → EXECI, with ALUSrcA=01 and ALUOp=00 forced
  - other → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, AdrSrc=1. Go to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=mem_ready. Go to FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=TakeBranch, with TakeBranch by funct3:
  - 000: Zero
  - 001: !Zero
  - 100 or 110: ALUR31
  - 101 or 111: !ALUR31
  - 010 or 011: 0, then go to TRAP instead of FETCH
  - otherwise go to FETCH
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB (writes OldPC+4).
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, then JAL. The datapath clears target bit 0.
- LUIWB: ResultSrc=11, RegWrite=1, then FETCH.
- MULSTART: mul_start=1, then MULWAIT.
- MULWAIT: hold until mul_done; in that cycle RegWrite=1, ResultSrc=10, then FETCH.
- TRAP: illegal=1, all strobes 0. Left only by reset.
- Any output not listed for a state is 0.

## Timing
- Reset: state=FETCH at the next edge. While reset is high, all strobes, mem_req, mul_start and instr_retired are 0 regardless of state. A reset mid-instruction aborts it with no partial write.
- Cycles with zero wait states:
  - lw 5, sw 4, R/I-type 4, auipc 4, lui 3
  - branch 3, jal 4, jalr 5
  - mul 4 + mul_done latency (minimum: mul_done in the first MULWAIT cycle)
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. The request and address are held stable throughout.
- instr_retired is asserted in MEMWB, ALUWB, LUIWB, the final MEMWRITE cycle, BRANCH (legal funct3), and the mul_done cycle. It is never asserted in TRAP.
- mem_ready or mul_done outside the state that awaits it is ignored.

## Test plan
- addi after reset, zero wait → states FETCH, DECODE, EXECI, ALUWB. RegWrite=1 only in cycle 4; instr_retired pulses in cycle 4.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total. AdrSrc=1 and mem_req held through MEMREAD; RegWrite with ResultSrc=01 once.
- beq/bne/blt/bgeu over all Zero/ALUR31 combinations → PCWrite in BRANCH matches the TakeBranch table. funct3=010 → TRAP with illegal=1 from the next cycle.
- M_EXT=1: mul with mul_done after 5 MULWAIT cycles → mul_start is one pulse, RegWrite in exactly the mul_done cycle. M_EXT=0: same encoding → takes the EXECR path.
- op=1111111 → TRAP, all strobes 0 for 20 cycles. Then reset=1 for one cycle → next instruction fetched normally.
- reset asserted during a MEMWRITE wait → MemWrite never pulses, FETCH follows. MEM_HANDSHAKE=0 with mem_ready tied low → lw completes in 5 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : RV32I multicycle main controller (FSM + ImmSrc decode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int M_EXT         = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_b0,
    input  logic       Zero,
    input  logic       ALUR31,
    input  logic       mem_ready,
    input  logic       mul_done,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       mem_req,
    output logic       mul_start,
    output logic       illegal,
    output logic       instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUIWB    = 4'd12,
        S_MULSTART = 4'd13,
        S_MULWAIT  = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    state_t state_q, state_d;
    logic   w_ready;
    logic   w_take_branch;
    logic   w_branch_legal;

    assign w_ready        = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign w_branch_legal = (funct3[2:1] != 2'b01);

    always_comb begin
        w_take_branch = 1'b0;
        case (funct3)
            3'b000:          w_take_branch = Zero;
            3'b001:          w_take_branch = ~Zero;
            3'b100, 3'b110:  w_take_branch = ALUR31;
            3'b101, 3'b111:  w_take_branch = ~ALUR31;
            default:         w_take_branch = 1'b0;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            c_OP_STORE:              ImmSrc = 3'b001;
            c_OP_BRANCH:             ImmSrc = 3'b010;
            c_OP_JAL:                ImmSrc = 3'b011;
            c_OP_LUI, c_OP_AUIPC:    ImmSrc = 3'b100;
            default:                 ImmSrc = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        PCWrite       = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        ALUOp         = 2'b00;
        mem_req       = 1'b0;
        mul_start     = 1'b0;
        illegal       = 1'b0;
        instr_retired = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_ready;
                PCWrite   = w_ready;
                if (w_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Precompute PC-relative target into ALUOut for branch/jal.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    c_OP_LOAD, c_OP_STORE: state_d = S_MEMADR;
                    c_OP_RTYPE:  state_d = ((M_EXT != 0) && funct7_b0) ? S_MULSTART : S_EXECR;
                    c_OP_ITYPE, c_OP_AUIPC: state_d = S_EXECI;
                    c_OP_BRANCH: state_d = S_BRANCH;
                    c_OP_JAL:    state_d = S_JAL;
                    c_OP_JALR:   state_d = S_JALR;
                    c_OP_LUI:    state_d = S_LUIWB;
                    default:     state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (w_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req       = 1'b1;
                AdrSrc        = 1'b1;
                MemWrite      = w_ready;
                instr_retired = w_ready;
                if (w_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                // auipc reuses this state but adds the immediate to OldPC.
                if (op == c_OP_AUIPC) begin
                    ALUSrcA = 2'b01;
                    ALUOp   = 2'b00;
                end else begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = 2'b10;
                ALUOp         = 2'b01;
                PCWrite       = w_take_branch;
                instr_retired = w_branch_legal;
                state_d       = w_branch_legal ? S_FETCH : S_TRAP;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JAL;
            end
            S_LUIWB: begin
                ResultSrc     = 2'b11;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_MULSTART: begin
                mul_start = 1'b1;
                state_d   = S_MULWAIT;
            end
            S_MULWAIT: begin
                if (mul_done) begin
                    RegWrite      = 1'b1;
                    ResultSrc     = 2'b10;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every side effect, whatever state we are in.
        if (reset) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            MemWrite      = 1'b0;
            mem_req       = 1'b0;
            mul_start     = 1'b0;
            instr_retired = 1'b0;
        end
    end

endmodule

`default_nettype wire
